// File: rtl/laser_obstacle_pkg.sv
// laser_obstacle_pkg: shared states, mode codes and lane geometry for the laser sweep obstacle
package laser_obstacle_pkg;
  typedef enum logic [1:0] {IDLE, SPAWN, GROW, HOLD} state_t;
  typedef enum logic [1:0] {MODE_PINGPONG = 2'd0, MODE_ONEWAY = 2'd1, MODE_ALL = 2'd2} mode_t;
  function automatic logic lane_hit(input int h, input int x0, input int w);
    return h >= x0 - w && h <= x0 + 1 + w;
  endfunction
endpackage

// File: rtl/laser_sweep_obstacle_delay_timer.sv
// obstacle_delay_timer: saturating cycle counter that flags the last cycle of a programmable delay
module obstacle_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] cnt;
  assign expire = en && cnt == limit - 1'b1;
  always_ff @(posedge clk)
    if (rst || load) cnt <= '0;
    else if (en && !expire) cnt <= cnt + 1'b1;
endmodule

// File: rtl/laser_sweep_obstacle.sv
// laser_sweep_obstacle: sequenced widening laser columns overlaid on the arena pixel stream
module laser_sweep_obstacle
  import laser_obstacle_pkg::*;
#(
  parameter int          NUM_LASERS     = 3,
  parameter int          FIRST_LASER_X  = 411,
  parameter int          LASER_PITCH    = 100,
  parameter int          LASER_TOP      = 317,
  parameter int          LASER_BOTTOM   = 617,
  parameter int          MAX_HALF_WIDTH = 30,
  parameter int          SPAWN_DELAY    = 32000000,
  parameter int          GROW_DELAY     = 3200000,
  parameter int          HOLD_DELAY     = 32000000,
  parameter logic [3:0]  SELECT_CODE    = 4'b0001,
  parameter logic [11:0] LASER_COLOR    = 12'hfff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic [11:0] rgb_in,
  input  logic        game_on,
  input  logic        menu_on,
  input  logic        play_selected,
  input  logic [3:0]  selected,
  input  logic        done_in,
  input  logic [1:0]  mode,
  output logic        working,
  output logic [11:0] rgb_out,
  output logic [11:0] obstacle_x,
  output logic [11:0] obstacle_y,
  output logic        done
);
  localparam int MAXD = SPAWN_DELAY > GROW_DELAY ? (SPAWN_DELAY > HOLD_DELAY ? SPAWN_DELAY : HOLD_DELAY)
                                                 : (GROW_DELAY > HOLD_DELAY ? GROW_DELAY : HOLD_DELAY);
  localparam int CW = $clog2(MAXD) + 1;
  localparam int WW = $clog2(MAX_HALF_WIDTH + 1);
  localparam int SW = 5;
  state_t state, state_n;
  mode_t mode_q, mode_n;
  logic [WW-1:0] w, w_n;
  logic [SW-1:0] step, step_n, lane;
  logic [CW-1:0] limit;
  logic load, expire, abort, start, last_step, done_n, hit;
  assign abort = state != IDLE && (menu_on || !play_selected);
  assign start = state == IDLE && done_in && game_on && play_selected && selected == SELECT_CODE;
  // ping-pong walks back down from the last lane after the first NUM_LASERS steps
  assign lane = mode_q == MODE_PINGPONG && step >= SW'(NUM_LASERS) ? SW'(2 * NUM_LASERS - 1) - step : step;
  assign last_step = step == (mode_q == MODE_ALL ? SW'(0) :
                              mode_q == MODE_ONEWAY ? SW'(NUM_LASERS - 1) : SW'(2 * NUM_LASERS - 1));
  assign limit = state == SPAWN ? CW'(SPAWN_DELAY) : state == GROW ? CW'(GROW_DELAY) : CW'(HOLD_DELAY);
  obstacle_delay_timer #(.W(CW)) u_timer (
    .clk(clk), .rst(rst), .load(load), .en(state != IDLE), .limit(limit), .expire(expire)
  );
  always_comb begin
    state_n = state;
    w_n = w;
    step_n = step;
    mode_n = mode_q;
    done_n = 1'b0;
    load = 1'b0;
    if (abort) begin
      state_n = IDLE;
      w_n = '0;
      load = 1'b1;
    end else if (start) begin
      state_n = SPAWN;
      w_n = '0;
      step_n = '0;
      mode_n = mode == MODE_ONEWAY || mode == MODE_ALL ? mode_t'(mode) : MODE_PINGPONG;
      load = 1'b1;
    end else if (expire) begin
      load = 1'b1;
      if (state == SPAWN) state_n = GROW;
      else if (state == GROW) begin
        w_n = w + 1'b1;
        state_n = w == WW'(MAX_HALF_WIDTH - 1) ? HOLD : GROW;
      end else if (last_step) begin
        state_n = IDLE;
        w_n = '0;
        done_n = 1'b1;
      end else begin
        state_n = SPAWN;
        w_n = '0;
        step_n = step + 1'b1;
      end
    end
  end
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_LASERS; i++)
      if ((mode_q == MODE_ALL || int'(lane) == i) &&
          lane_hit(int'(hcount_in), FIRST_LASER_X + i * LASER_PITCH, int'(w)))
        hit = 1'b1;
    hit = hit && state != IDLE && vcount_in >= 12'(LASER_TOP) && vcount_in <= 12'(LASER_BOTTOM);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      mode_q <= MODE_PINGPONG;
      w <= '0;
      step <= '0;
      done <= 1'b0;
      working <= 1'b0;
      rgb_out <= '0;
      obstacle_x <= '0;
      obstacle_y <= '0;
    end else begin
      state <= state_n;
      mode_q <= mode_n;
      w <= w_n;
      step <= step_n;
      done <= done_n;
      working <= state_n != IDLE;
      rgb_out <= hit ? LASER_COLOR : rgb_in;
      obstacle_x <= hit ? hcount_in : '0;
      obstacle_y <= hit ? vcount_in : '0;
    end
endmodule

// File: tb/tb_laser_sweep_obstacle.sv
// tb_laser_sweep_obstacle: scoreboard bench for lane sequencing, pixel overlay, abort and reset
module tb_laser_sweep_obstacle;
  localparam int N = 3, SD = 4, GD = 2, HD = 3, MW = 2, STEP = SD + MW * GD + HD;
  localparam int X0 = 411, P = 100, TOP = 317, BOT = 617;
  logic clk = 1'b0, rst = 1'b1;
  logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0;
  logic game_on = 1'b1, menu_on = 1'b0, play_selected = 1'b1, done_in = 1'b0;
  logic [3:0] selected = '0;
  logic [1:0] mode = '0;
  logic working, done;
  logic [11:0] rgb_out, obstacle_x, obstacle_y;
  int checks = 0, errors = 0;
  logic [35:0] pix_q[$];
  logic [2:0] lane_q[$];
  always #5 clk = ~clk;
  laser_sweep_obstacle #(
    .NUM_LASERS(N), .SPAWN_DELAY(SD), .GROW_DELAY(GD), .HOLD_DELAY(HD), .MAX_HALF_WIDTH(MW)
  ) dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in), .rgb_in(rgb_in),
    .game_on(game_on), .menu_on(menu_on), .play_selected(play_selected), .selected(selected),
    .done_in(done_in), .mode(mode), .working(working), .rgb_out(rgb_out),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y), .done(done)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [35:0] model(input int h, input int v, input logic [11:0] rgb,
                                        input logic act, input logic [2:0] m, input int w);
    logic lit;
    lit = 1'b0;
    if (act && v >= TOP && v <= BOT)
      for (int i = 0; i < N; i++)
        if (m[i] && h >= X0 + i * P - w && h <= X0 + i * P + 1 + w) lit = 1'b1;
    return lit ? {12'hfff, 12'(h), 12'(v)} : {rgb, 24'd0};
  endfunction
  task automatic test_reset;
    rst = 1'b1;
    rgb_in = 12'h3c3;
    tick;
    tick;
    checks++;
    if ({working, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got %b want 00", {working, done});
    end
    checks++;
    if ({rgb_out, obstacle_x, obstacle_y} !== 36'd0) begin
      errors++;
      $display("FAIL reset_pixel got %h want 0", {rgb_out, obstacle_x, obstacle_y});
    end
    rst = 1'b0;
  endtask
  task automatic run_seq(input string name, input logic [1:0] md, input int nsteps,
                         input logic [17:0] seq, input int kill_c, input bit kill_rst, input int junk_c);
    int total, stop, p, s, w, h, v, pulses;
    logic act;
    logic [2:0] obs, m;
    logic [35:0] exp;
    total = nsteps * STEP;
    stop = kill_c > 0 ? kill_c : total;
    pulses = 0;
    obs = '0;
    for (int i = 0; i < nsteps; i++) lane_q.push_back(seq[3*i +: 3]);
    selected = 4'b0001;
    mode = md;
    done_in = 1'b1;
    tick;
    done_in = 1'b0;
    checks++;
    if (working !== 1'b1) begin
      errors++;
      $display("FAIL %s start_working got %b want 1", name, working);
    end
    for (int c = 1; c <= total + 4; c++) begin
      p = (c - 1) % STEP;
      s = (c - 1) / STEP;
      w = p < SD ? 0 : p >= SD + MW * GD ? MW : (p - SD) / GD;
      act = c <= stop;
      m = s < nsteps ? seq[3*s +: 3] : 3'b000;
      if (p < 3) begin h = X0 + p * P; v = TOP; end
      else if (p == 8) begin h = 509; v = 317; end
      else if (p == 9) begin h = 508; v = 317; end
      else if (p == 10) begin h = 509; v = 618; end
      else begin h = $urandom_range(660, 380); v = $urandom_range(640, 300); end
      hcount_in = 12'(h);
      vcount_in = 12'(v);
      rgb_in = 12'($urandom);
      menu_on = c == kill_c && !kill_rst;
      rst = c == kill_c && kill_rst;
      done_in = c == junk_c;
      if (c == junk_c) mode = md ^ 2'b01;
      pix_q.push_back(c == kill_c && kill_rst ? 36'd0 : model(h, v, rgb_in, act, m, w));
      tick;
      exp = pix_q.pop_front();
      checks++;
      if ({rgb_out, obstacle_x, obstacle_y} !== exp) begin
        errors++;
        $display("FAIL %s pixel c=%0d got %h want %h", name, c, {rgb_out, obstacle_x, obstacle_y}, exp);
      end
      checks++;
      if (working !== (c < stop)) begin
        errors++;
        $display("FAIL %s working c=%0d got %b want %b", name, c, working, c < stop);
      end
      checks++;
      if (done !== (c == total && kill_c == 0)) begin
        errors++;
        $display("FAIL %s done c=%0d got %b want %b", name, c, done, c == total && kill_c == 0);
      end
      if (done === 1'b1) pulses++;
      if (p < 3 && act) obs[p] = rgb_out == 12'hfff;
      if (p == 2 && act && lane_q.size() > 0) begin
        m = lane_q.pop_front();
        checks++;
        if (obs !== m) begin
          errors++;
          $display("FAIL %s lanes step=%0d got %b want %b", name, s, obs, m);
        end
      end
    end
    menu_on = 1'b0;
    rst = 1'b0;
    done_in = 1'b0;
    checks++;
    if (pulses != (kill_c == 0 ? 1 : 0)) begin
      errors++;
      $display("FAIL %s done_pulses got %0d want %0d", name, pulses, kill_c == 0 ? 1 : 0);
    end
    if (kill_c == 0) begin
      checks++;
      if (lane_q.size() != 0) begin
        errors++;
        $display("FAIL %s lanes_left got %0d want 0", name, lane_q.size());
      end
    end
    lane_q.delete();
  endtask
  task automatic test_pingpong;
    run_seq("pingpong", 2'd0, 2 * N, {3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001}, 0, 1'b0, 0);
  endtask
  task automatic test_oneway;
    run_seq("oneway", 2'd1, N, {9'd0, 3'b100, 3'b010, 3'b001}, 0, 1'b0, 0);
  endtask
  task automatic test_all;
    run_seq("all", 2'd2, 1, {15'd0, 3'b111}, 0, 1'b0, 0);
  endtask
  task automatic test_mode3;
    run_seq("mode3", 2'd3, 2 * N, {3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001}, 0, 1'b0, 0);
  endtask
  task automatic test_abort;
    run_seq("abort", 2'd0, 2 * N, {3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001}, STEP + 5, 1'b0, 0);
  endtask
  task automatic test_ignore_done_in;
    run_seq("ignore", 2'd0, 2 * N, {3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001}, 0, 1'b0, 30);
  endtask
  task automatic test_wrong_start;
    selected = 4'b0010;
    done_in = 1'b1;
    tick;
    checks++;
    if (working !== 1'b0) begin
      errors++;
      $display("FAIL wrong_select working got %b want 0", working);
    end
    selected = 4'b0001;
    game_on = 1'b0;
    tick;
    done_in = 1'b0;
    game_on = 1'b1;
    checks++;
    if (working !== 1'b0) begin
      errors++;
      $display("FAIL game_off working got %b want 0", working);
    end
    hcount_in = 12'd411;
    vcount_in = 12'd317;
    rgb_in = 12'h0a0;
    tick;
    checks++;
    if ({rgb_out, obstacle_x, obstacle_y} !== {12'h0a0, 24'd0}) begin
      errors++;
      $display("FAIL idle_pass got %h want %h", {rgb_out, obstacle_x, obstacle_y}, {12'h0a0, 24'd0});
    end
  endtask
  task automatic test_reset_mid;
    run_seq("rst_mid", 2'd0, 2 * N, {3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001}, STEP + 10, 1'b1, 0);
  endtask
  task automatic test_back_to_back;
    run_seq("replay", 2'd0, 2 * N, {3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001}, 0, 1'b0, 0);
  endtask
  initial begin
    test_reset;
    test_pingpong;
    test_oneway;
    test_all;
    test_mode3;
    test_abort;
    test_wrong_start;
    test_ignore_done_in;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
